// File: rtl/uart_cnt_reporter.sv
// Reports a sampled 14-bit counter value over UART TX as fixed-width ASCII decimal plus CR/LF.
// Define CNT_RPT_ZERO_BLANK_EN to suppress leading zero digits; the units digit is always sent.
module uart_cnt_reporter #(
  parameter bit SEND_CR = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_trig,
  input  logic [13:0] i_value,
  input  logic        i_tx_done,
  output logic        o_tx_start,
  output logic [7:0]  o_tx_data,
  output logic        o_busy,
  output logic        o_done
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CONVERT = 3'd1,
    SEND    = 3'd2,
    WAIT    = 3'd3,
    FINISH  = 3'd4
  } state_t;

  localparam logic [2:0] LAST_IDX = SEND_CR ? 3'd5 : 3'd4;

  state_t      state_q;
  logic [13:0] bin_q,  bin_d;
  logic [15:0] bcd_q,  bcd_d;
  logic [15:0] bcd_adj;
  logic [3:0]  iter_q;
  logic [2:0]  idx_q;
  logic [2:0]  lead;
  logic [2:0]  sel_idx;
  logic [7:0]  byte_sel;
  logic [13:0] sat_value;
  logic        tx_start_q;
  logic [7:0]  tx_data_q;
  logic        busy_q;
  logic        done_q;

  assign sat_value = (i_value >= 14'd10000) ? 14'd9999 : i_value;

  // One double-dabble step: add 3 to each nibble >= 5, then shift {bcd,bin} left.
  always_comb begin
    bcd_adj = bcd_q;
    for (int n = 0; n < 4; n++) begin
      if (bcd_q[4*n +: 4] >= 4'd5) bcd_adj[4*n +: 4] = bcd_q[4*n +: 4] + 4'd3;
    end
    bcd_d = {bcd_adj[14:0], bin_q[13]};
    bin_d = {bin_q[12:0], 1'b0};
  end

  always_comb begin
    lead = 3'd0;
`ifdef CNT_RPT_ZERO_BLANK_EN
    if (bcd_q[15:12] == 4'd0) begin
      lead = 3'd1;
      if (bcd_q[11:8] == 4'd0) begin
        lead = 3'd2;
        if (bcd_q[7:4] == 4'd0) lead = 3'd3;
      end
    end
`endif
  end

  // Blanked digits are jumped over inside the SEND cycle, so they cost no time.
  assign sel_idx = (idx_q < lead) ? lead : idx_q;

  always_comb begin
    byte_sel = 8'h0A;
    case (sel_idx)
      3'd0:    byte_sel = {4'h3, bcd_q[15:12]};
      3'd1:    byte_sel = {4'h3, bcd_q[11:8]};
      3'd2:    byte_sel = {4'h3, bcd_q[7:4]};
      3'd3:    byte_sel = {4'h3, bcd_q[3:0]};
      3'd4:    byte_sel = SEND_CR ? 8'h0D : 8'h0A;
      default: byte_sel = 8'h0A;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      iter_q     <= '0;
      idx_q      <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (i_trig) begin
            bin_q   <= sat_value;
            bcd_q   <= '0;
            iter_q  <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= CONVERT;
          end
        end
        CONVERT: begin
          bcd_q  <= bcd_d;
          bin_q  <= bin_d;
          iter_q <= iter_q + 4'd1;
          if (iter_q == 4'd13) state_q <= SEND;
        end
        SEND: begin
          tx_start_q <= 1'b1;
          tx_data_q  <= byte_sel;
          idx_q      <= sel_idx;
          state_q    <= WAIT;
        end
        WAIT: begin
          tx_start_q <= 1'b0;
          // A done coinciding with our own start pulse belongs to nothing we sent.
          if (i_tx_done && !tx_start_q) begin
            if (idx_q == LAST_IDX) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= FINISH;
            end else begin
              idx_q   <= idx_q + 3'd1;
              state_q <= SEND;
            end
          end
        end
        FINISH: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_tx_start = tx_start_q;
  assign o_tx_data  = tx_data_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;

endmodule

// File: tb/tb_uart_cnt_reporter.sv
// Scoreboard bench: two reporters (with and without CR) share stimulus; a monitor checks every byte.
module tb_uart_cnt_reporter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        trig = 1'b0;
  logic [13:0] value = '0;
  logic        resp1 = 1'b0, resp0 = 1'b0, spur = 1'b0;
  logic [1:0]  tx_done_w;
  logic [1:0]  start_w, busy_w, done_w;
  logic [7:0]  data_w [2];

  assign tx_done_w = {resp1 | spur, resp0 | spur};

  uart_cnt_reporter #(.SEND_CR(1'b1)) dut1 (
    .clk(clk), .reset(rst_n), .i_trig(trig), .i_value(value), .i_tx_done(tx_done_w[1]),
    .o_tx_start(start_w[1]), .o_tx_data(data_w[1]), .o_busy(busy_w[1]), .o_done(done_w[1]));

  uart_cnt_reporter #(.SEND_CR(1'b0)) dut0 (
    .clk(clk), .reset(rst_n), .i_trig(trig), .i_value(value), .i_tx_done(tx_done_w[0]),
    .o_tx_start(start_w[0]), .o_tx_data(data_w[0]), .o_busy(busy_w[0]), .o_done(done_w[0]));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int         checks = 0, failures = 0;
  logic [7:0] q [2][$];
  int         dcnt [2] = '{0, 0};
  int         sent [2] = '{0, 0};
  int         edone = 0;
  int         trig_cyc = 0;
  logic [7:0] last [2];
  bit         seen [2] = '{0, 0};
  bit         first [2] = '{0, 0};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every start, checks data hold and done framing.
  always @(negedge clk) begin
    if (!rst_n) begin
      seen[0] = 0; seen[1] = 0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (start_w[i]) begin
          if (first[i]) begin
            chk($sformatf("first_start_latency%0d", i), cyc - trig_cyc, 15);
            first[i] = 0;
          end
          if (q[i].size() == 0) chk($sformatf("unexpected_start%0d", i), 1, 0);
          else chk($sformatf("byte%0d", i), int'(data_w[i]), int'(q[i].pop_front()));
          last[i] = data_w[i];
          seen[i] = 1;
          sent[i]++;
        end else if (busy_w[i] && seen[i]) begin
          chk($sformatf("data_hold%0d", i), int'(data_w[i]), int'(last[i]));
        end
        if (done_w[i]) begin
          dcnt[i]++;
          chk($sformatf("busy_low_at_done%0d", i), int'(busy_w[i]), 0);
          seen[i] = 0;
        end
      end
    end
  end

  // UART TX stand-ins: answer each start with tx_done ten cycles later.
  initial forever begin
    @(negedge clk);
    if (start_w[1]) begin
      repeat (10) @(negedge clk);
      resp1 = 1'b1; @(negedge clk); resp1 = 1'b0;
    end
  end
  initial forever begin
    @(negedge clk);
    if (start_w[0]) begin
      repeat (10) @(negedge clk);
      resp0 = 1'b1; @(negedge clk); resp0 = 1'b0;
    end
  end

  // Reference: decimal digits by arithmetic, saturated at 9999.
  task automatic push_expected(input int v);
    int s, fst;
    int d [4];
    s = (v > 9999) ? 9999 : v;
    d[0] = s / 1000; d[1] = (s / 100) % 10; d[2] = (s / 10) % 10; d[3] = s % 10;
    fst = 0;
`ifdef CNT_RPT_ZERO_BLANK_EN
    while (fst < 3 && d[fst] == 0) fst++;
`endif
    for (int k = fst; k < 4; k++) begin
      q[0].push_back(8'(8'h30 + d[k]));
      q[1].push_back(8'(8'h30 + d[k]));
    end
    q[1].push_back(8'h0D);
    q[0].push_back(8'h0A);
    q[1].push_back(8'h0A);
  endtask

  task automatic start_txn(input int v, input bit spurious, input bit extra);
    push_expected(v);
    edone++;
    first[0] = 1; first[1] = 1;
    @(negedge clk);
    value = 14'(v);
    trig = 1'b1;
    @(posedge clk);
    #1 trig_cyc = cyc;
    @(negedge clk);
    trig = 1'b0;
    value = 14'($urandom);
    if (spurious) begin
      repeat (2) @(negedge clk);
      spur = 1'b1; @(negedge clk); spur = 1'b0;
    end
    if (extra) begin
      repeat (20) @(negedge clk);
      trig = 1'b1; @(negedge clk); trig = 1'b0;
      repeat (20) @(negedge clk);
      trig = 1'b1; @(negedge clk); trig = 1'b0;
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while ((dcnt[0] != edone || dcnt[1] != edone) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("finished_within_bound", int'(n < 400), 1);
    repeat (2) @(negedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("done_count%0d", i), dcnt[i], edone);
      chk($sformatf("bytes_remaining%0d", i), q[i].size(), 0);
      chk($sformatf("busy_after%0d", i), int'(busy_w[i]), 0);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s_start%0d", tag, i), int'(start_w[i]), 0);
      chk($sformatf("%s_data%0d", tag, i), int'(data_w[i]), 0);
      chk($sformatf("%s_busy%0d", tag, i), int'(busy_w[i]), 0);
      chk($sformatf("%s_done%0d", tag, i), int'(done_w[i]), 0);
    end
  endtask

  initial begin
    int n, v;
    #1 chk_outputs_zero("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    start_txn(1234, 1'b1, 1'b1); wait_done();
    start_txn(0,     1'b0, 1'b0); wait_done();
    start_txn(16383, 1'b0, 1'b0); wait_done();
    start_txn(10000, 1'b0, 1'b0); wait_done();
    start_txn(9999,  1'b0, 1'b0); wait_done();
    start_txn(507,   1'b0, 1'b0); wait_done();
    for (int r = 0; r < 8; r++) begin
      v = (r % 2 == 0) ? int'($urandom_range(0, 16383)) : int'($urandom_range(0, 120));
      start_txn(v, 1'b0, 1'b0);
      wait_done();
    end

    // Abort mid-stream while waiting on the second byte.
    n = sent[1];
    start_txn(4321, 1'b0, 1'b0);
    v = 0;
    while (sent[1] < n + 2 && v < 200) begin @(negedge clk); v++; end
    chk("reached_second_byte", int'(v < 200), 1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_outputs_zero("async_reset");
    q[0].delete(); q[1].delete();
    first[0] = 0; first[1] = 0;
    edone--;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    chk("no_done_after_abort1", dcnt[1], edone);
    chk("no_done_after_abort0", dcnt[0], edone);

    start_txn(88, 1'b0, 1'b0); wait_done();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
